// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter sweep controller.
//   - state_t : sequencer states (idle, running a sweep, end-of-sweep pulse)
//   - DIR_UP / DIR_DOWN : direction encoding used on cmd_dir and dir
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_n_step_unit.sv
// mod_n_step_unit: combinational single step of a mod-N up/down counter.
// Ports:
//   i_count      - current count, expected in 0..N-1
//   i_dir        - current direction (DIR_UP / DIR_DOWN)
//   i_pingpong   - 1: reverse direction at the boundary, 0: wrap around
//   o_next_count - count after one step, always in 0..N-1
//   o_next_dir   - direction after the step (changes only on a pingpong reversal)
//   o_wrap_evt   - 1 when this step wraps modulo N (wrap mode only)
module mod_n_step_unit
  import counter_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned B = 4
) (
  input  logic [B-1:0] i_count,
  input  logic         i_dir,
  input  logic         i_pingpong,
  output logic [B-1:0] o_next_count,
  output logic         o_next_dir,
  output logic         o_wrap_evt
);

  localparam logic [B-1:0] CntMax   = B'(N - 1);
  localparam logic [B-1:0] CntMaxM1 = B'(N - 2);
  localparam logic [B-1:0] CntOne   = B'(1);

  always_comb begin
    o_next_count = i_count;
    o_next_dir   = i_dir;
    o_wrap_evt   = 1'b0;
    if (i_dir == DIR_UP) begin
      // >= rather than == so an out-of-range value can never step further up
      if (i_count >= CntMax) begin
        if (i_pingpong) begin
          o_next_dir   = DIR_DOWN;
          o_next_count = CntMaxM1;
        end else begin
          o_next_count = '0;
          o_wrap_evt   = 1'b1;
        end
      end else begin
        o_next_count = i_count + 1'b1;
      end
    end else begin
      if (i_count == '0) begin
        if (i_pingpong) begin
          o_next_dir   = DIR_UP;
          o_next_count = CntOne;
        end else begin
          o_next_count = CntMax;
          o_wrap_evt   = 1'b1;
        end
      end else if (i_count > CntMax) begin
        o_next_count = CntMax;
      end else begin
        o_next_count = i_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: command-driven sequencer for a mod-N up/down count register.
// A host issues a sweep (direction, wrap/pingpong mode, step count); the count
// then steps once per cycle until the steps are exhausted or the sweep is aborted.
// Ports:
//   i_clk, i_rst     - clock; synchronous active-high reset
//   i_cmd_valid      - command present; accepted when o_cmd_ready is high
//   o_cmd_ready      - high only in idle
//   i_cmd_dir        - 1 = up, 0 = down
//   i_cmd_pingpong   - 1 = reverse at the boundary instead of wrapping
//   i_cmd_len        - number of steps in the sweep
//   i_hold           - freeze stepping while high
//   i_abort          - end the active sweep (wins over hold)
//   o_count, o_dir   - registered count and direction
//   o_busy           - high while a sweep is running
//   o_done           - one-cycle end-of-sweep pulse
//   o_wrap           - one-cycle pulse, coincident with the wrapped count value
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned B = 4,
  parameter int unsigned L = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic         i_cmd_dir,
  input  logic         i_cmd_pingpong,
  input  logic [L-1:0] i_cmd_len,
  input  logic         i_hold,
  input  logic         i_abort,
  output logic [B-1:0] o_count,
  output logic         o_dir,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_wrap
);

  state_t         r_state;
  logic [B-1:0]   r_count;
  logic           r_dir;
  logic           r_pp;
  logic [L-1:0]   r_remaining;
  logic           r_busy;
  logic           r_done;
  logic           r_wrap;
  logic           r_ready;

  logic [B-1:0]   w_next_count;
  logic           w_next_dir;
  logic           w_wrap_evt;

  mod_n_step_unit #(
    .N (N),
    .B (B)
  ) u_step (
    .i_count      (r_count),
    .i_dir        (r_dir),
    .i_pingpong   (r_pp),
    .o_next_count (w_next_count),
    .o_next_dir   (w_next_dir),
    .o_wrap_evt   (w_wrap_evt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_dir       <= DIR_UP;
      r_pp        <= 1'b0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      // Pulses default low; only a wrapping step or end of sweep raises them.
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_dir       <= i_cmd_dir;
            r_pp        <= i_cmd_pingpong;
            r_remaining <= i_cmd_len;
            r_ready     <= 1'b0;
            if (i_cmd_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (!i_hold) begin
            r_count     <= w_next_count;
            r_dir       <= w_next_dir;
            r_wrap      <= w_wrap_evt;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == L'(1)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_count     = r_count;
  assign o_dir       = r_dir;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wrap      = r_wrap;

endmodule
